// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern engine and its compaction blocks.
package bist_pkg;

  localparam int IN_W   = 12;
  localparam int OUT_W  = 4;
  localparam int MISR_W = 16;

  // Feedback tap masks: LFSR x^12+x^6+x^4+x+1, MISR taps at bits 15, 11 and 4.
  localparam logic [IN_W-1:0]   LFSR_TAPS = 12'h829;
  localparam logic [MISR_W-1:0] MISR_TAPS = 16'h8810;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift with tap feedback, then XOR the response into the low bits.
module bist_misr #(
  parameter int              W    = 16,
  parameter int              D_W  = 4,
  parameter logic [W-1:0]    TAPS = 16'h8810
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           en,
  input  logic [D_W-1:0] d_in,
  output logic [W-1:0]   sig
);

  logic [W-1:0] sig_next;

  assign sig_next = {sig[W-2:0], ^(sig & TAPS)} ^ {{(W-D_W){1'b0}}, d_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clear) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/bist_pattern_engine.sv
// BIST driver: applies counter or LFSR vectors to a combinational datapath and compacts its responses.
module bist_pattern_engine
  import bist_pkg::*;
#(
  parameter logic [IN_W-1:0] LFSR_SEED = 12'h001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [12:0]       num_pat,
  input  logic [MISR_W-1:0] golden_sig,
  input  logic [OUT_W-1:0]  resp_in,
  output logic [IN_W-1:0]   pat_out,
  output logic              pat_valid,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] sig_out,
  output logic              pass
);

  localparam logic [IN_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;

  state_e           state_q, state_d;
  logic             mode_q;
  logic [12:0]      remaining_q;
  logic [IN_W-1:0]  pat_q;
  logic [IN_W-1:0]  pat_next;
  logic             accept;
  logic             last_vec;

  assign accept   = start && (state_q != RUN);
  assign last_vec = (remaining_q == 13'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (num_pat == 13'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_vec) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pat_next = pat_q + IN_W'(1);
    if (mode_q) begin
      pat_next = {pat_q[IN_W-2:0], ^(pat_q & LFSR_TAPS)};
    end
  end

  // The final vector is not advanced past, so pat_out keeps the last applied vector after the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= 1'b0;
      remaining_q <= '0;
      pat_q       <= '0;
    end else if (accept) begin
      mode_q      <= mode;
      remaining_q <= num_pat;
      if (num_pat != 13'd0) begin
        pat_q <= mode ? SEED_EFF : '0;
      end
    end else if (state_q == RUN) begin
      remaining_q <= remaining_q - 13'd1;
      if (!last_vec) begin
        pat_q <= pat_next;
      end
    end
  end

  bist_misr #(
    .W    (MISR_W),
    .D_W  (OUT_W),
    .TAPS (MISR_TAPS)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (state_q == RUN),
    .d_in  (resp_in),
    .sig   (sig_out)
  );

  assign pat_out   = pat_q;
  assign pat_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (sig_out == golden_sig);

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Self-checking bench: a random datapath ROM drives resp_in, and a behavioural model predicts vectors and signatures.
module tb_bist_pattern_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [12:0] num_pat;
  logic [15:0] golden_sig;
  logic [3:0]  resp_in;
  logic [11:0] pat_out;
  logic        pat_valid;
  logic        busy;
  logic        done;
  logic [15:0] sig_out;
  logic        pass;

  logic [3:0]  dp_rom [0:4095];
  logic        resp_force_en;
  logic [3:0]  resp_force_val;
  logic [11:0] last_pat;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign resp_in = resp_force_en ? resp_force_val : dp_rom[pat_out];

  bist_pattern_engine #(.LFSR_SEED(12'h001)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .num_pat    (num_pat),
    .golden_sig (golden_sig),
    .resp_in    (resp_in),
    .pat_out    (pat_out),
    .pat_valid  (pat_valid),
    .busy       (busy),
    .done       (done),
    .sig_out    (sig_out),
    .pass       (pass)
  );

  // Vector sequence rule: counter increments mod 4096; LFSR shifts left with x^12+x^6+x^4+x+1 feedback.
  function automatic logic [11:0] nextVec(input bit m, input logic [11:0] v);
    int q;
    int fb;
    q = int'(v);
    if (!m) return 12'((q + 1) % 4096);
    fb = ((q >> 11) ^ (q >> 5) ^ (q >> 3) ^ q) & 1;
    return 12'(((q << 1) | fb) & 12'hFFF);
  endfunction

  function automatic logic [15:0] modelSig(input bit m, input int n, input bit fen, input logic [3:0] fval);
    int s;
    int fb;
    int r;
    logic [11:0] v;
    s = 0;
    v = m ? 12'h001 : 12'h000;
    for (int i = 0; i < n; i++) begin
      r  = fen ? int'(fval) : int'(dp_rom[v]);
      fb = ((s >> 15) ^ (s >> 11) ^ (s >> 4)) & 1;
      s  = (((s << 1) | fb) & 16'hFFFF) ^ r;
      v  = nextVec(m, v);
    end
    return 16'(s);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit m, input logic [12:0] n);
    @(negedge clk);
    mode    = m;
    num_pat = n;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input bit m, input int n, input logic [15:0] golden,
                             input int pulse_at);
    logic [11:0] v;
    logic [15:0] exp_sig;
    exp_sig    = modelSig(m, n, resp_force_en, resp_force_val);
    golden_sig = golden;
    applyStimulus(m, 13'(n));
    v = m ? 12'h001 : 12'h000;
    for (int i = 1; i <= n; i++) begin
      checkOutput({tag, "_pat"}, 16'(pat_out), 16'(v));
      checkOutput({tag, "_valid"}, 16'(pat_valid), 16'd1);
      checkOutput({tag, "_busy"}, 16'(busy), 16'd1);
      checkOutput({tag, "_done_low"}, 16'(done), 16'd0);
      if (i == pulse_at) begin
        start   = 1'b1;
        mode    = ~m;
        num_pat = 13'd2;
      end
      @(negedge clk);
      start = 1'b0;
      if (i < n) v = nextVec(m, v);
    end
    if (n == 0) v = last_pat;
    checkOutput({tag, "_done"}, 16'(done), 16'd1);
    checkOutput({tag, "_busy_end"}, 16'(busy), 16'd0);
    checkOutput({tag, "_valid_end"}, 16'(pat_valid), 16'd0);
    checkOutput({tag, "_sig"}, sig_out, exp_sig);
    checkOutput({tag, "_pass"}, 16'(pass), 16'(exp_sig == golden));
    checkOutput({tag, "_hold"}, 16'(pat_out), 16'(v));
    @(negedge clk);
    checkOutput({tag, "_done_held"}, 16'(done), 16'd1);
    checkOutput({tag, "_sig_frozen"}, sig_out, exp_sig);
    last_pat = v;
  endtask

  initial begin
    logic [15:0] g;
    bit          rm;
    int          rn;
    for (int a = 0; a < 4096; a++) dp_rom[a] = 4'($urandom);
    rst            = 1'b1;
    start          = 1'b0;
    mode           = 1'b0;
    num_pat        = 13'd0;
    golden_sig     = 16'h0000;
    resp_force_en  = 1'b1;
    resp_force_val = 4'h0;
    last_pat       = 12'h000;
    repeat (2) @(negedge clk);
    checkOutput("reset_pat", 16'(pat_out), 16'd0);
    checkOutput("reset_valid", 16'(pat_valid), 16'd0);
    checkOutput("reset_busy", 16'(busy), 16'd0);
    checkOutput("reset_done", 16'(done), 16'd0);
    checkOutput("reset_sig", sig_out, 16'd0);
    checkOutput("reset_pass", 16'(pass), 16'd0);
    rst = 1'b0;

    $display("[TB] counter mode, 4 vectors, zero response");
    runAndCheck("cnt4", 1'b0, 4, 16'h0000, 0);

    $display("[TB] LFSR mode, 3 and 4 vectors");
    runAndCheck("lfsr3", 1'b1, 3, 16'h1234, 0);
    runAndCheck("lfsr4", 1'b1, 4, 16'h0000, 0);
    checkOutput("lfsr4_last", 16'(pat_out), 16'h000F);

    $display("[TB] single-vector MISR check");
    resp_force_val = 4'h1;
    runAndCheck("misr1_bad", 1'b0, 1, 16'h0002, 0);
    checkOutput("misr1_sig", sig_out, 16'h0001);
    runAndCheck("misr1_good", 1'b0, 1, 16'h0001, 0);
    checkOutput("misr1_pass", 16'(pass), 16'd1);

    $display("[TB] zero-length run");
    resp_force_en = 1'b0;
    runAndCheck("zero", 1'b1, 0, 16'h0000, 0);

    $display("[TB] start pulsed mid-run, then relaunch from DONE");
    runAndCheck("ignore6", 1'b0, 6, 16'hBEEF, 3);
    runAndCheck("relaunch", 1'b0, 5, 16'h0000, 0);

    $display("[TB] reset in the middle of a run");
    applyStimulus(1'b0, 13'd10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_pat", 16'(pat_out), 16'd0);
    checkOutput("midrst_valid", 16'(pat_valid), 16'd0);
    checkOutput("midrst_busy", 16'(busy), 16'd0);
    checkOutput("midrst_done", 16'(done), 16'd0);
    checkOutput("midrst_sig", sig_out, 16'd0);
    checkOutput("midrst_pass", 16'(pass), 16'd0);
    @(negedge clk);
    rst      = 1'b0;
    last_pat = 12'h000;
    runAndCheck("after_rst", 1'b1, 7, 16'h0000, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      rm = 1'($urandom_range(0, 1));
      rn = int'($urandom_range(1, 300));
      g  = (r % 2 == 0) ? modelSig(rm, rn, 1'b0, 4'h0) : 16'($urandom);
      runAndCheck("rand", rm, rn, g, (r % 3 == 0) ? int'($urandom_range(1, rn)) : 0);
    end

    $display("[TB] full exhaustive and LFSR wrap runs");
    runAndCheck("full_cnt", 1'b0, 4096, modelSig(1'b0, 4096, 1'b0, 4'h0), 0);
    runAndCheck("lfsr_wrap", 1'b1, 4100, 16'h0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
